// File: rtl/regpool_access_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master port between NUM_REQ requesters.
// Exactly one AXI transaction is in flight at a time; the response is pulsed back to the owner.
module regpool_access_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             rsp_err,
    output logic                             busy,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic [ADDR_WIDTH-1:0]            axil_awaddr,
    output logic [2:0]                       axil_awprot,
    output logic                             axil_awvalid,
    input  logic                             axil_awready,
    output logic [DATA_WIDTH-1:0]            axil_wdata,
    output logic [DATA_WIDTH/8-1:0]          axil_wstrb,
    output logic                             axil_wvalid,
    input  logic                             axil_wready,
    input  logic [1:0]                       axil_bresp,
    input  logic                             axil_bvalid,
    output logic                             axil_bready,
    output logic [ADDR_WIDTH-1:0]            axil_araddr,
    output logic [2:0]                       axil_arprot,
    output logic                             axil_arvalid,
    input  logic                             axil_arready,
    input  logic [DATA_WIDTH-1:0]            axil_rdata,
    input  logic [1:0]                       axil_rresp,
    input  logic                             axil_rvalid,
    output logic                             axil_rready
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t                 state_reg, state_next;
    logic [IDW-1:0]         rr_ptr_reg;
    logic [IDW-1:0]         grant_id_reg;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [DATA_WIDTH-1:0]  wdata_reg;
    logic                   aw_done_reg, w_done_reg;
    logic [NUM_REQ-1:0]     rsp_valid_reg;
    logic [DATA_WIDTH-1:0]  rsp_data_reg;
    logic                   rsp_err_reg;

    logic [ADDR_WIDTH-1:0]  req_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  req_wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]     grant_onehot;
    logic [IDW-1:0]         cand;
    logic [IDW-1:0]         win_idx;
    logic                   win_found;
    logic                   grant_fire;
    logic                   aw_hs, w_hs, b_hs, r_hs;
    logic                   unused_resp_bits;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign req_ready[gi]     = grant_fire && !areset && (win_idx == IDW'(gi));
        assign grant_onehot[gi]  = (grant_id_reg == IDW'(gi));
    end

    // Scan starts one past the last winner so a persistent requester cannot starve the others.
    always_comb begin
        cand      = rr_ptr_reg;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign aw_hs = axil_awvalid && axil_awready;
    assign w_hs  = axil_wvalid && axil_wready;
    assign b_hs  = axil_bvalid && axil_bready;
    assign r_hs  = axil_rvalid && axil_rready;

    always_comb begin
        state_next = state_reg;
        grant_fire = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    grant_fire = 1'b1;
                    state_next = req_we[win_idx] ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = WR_RESP;
            WR_RESP: if (b_hs) state_next = IDLE;
            RD_ADDR: if (axil_arvalid && axil_arready) state_next = RD_DATA;
            RD_DATA: if (r_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= LAST_ID;
            grant_id_reg  <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rsp_valid_reg <= '0;
            if (grant_fire) begin
                addr_reg     <= req_addr_arr[win_idx];
                wdata_reg    <= req_wdata_arr[win_idx];
                rr_ptr_reg   <= win_idx;
                grant_id_reg <= win_idx;
                aw_done_reg  <= 1'b0;
                w_done_reg   <= 1'b0;
            end
            if (aw_hs) aw_done_reg <= 1'b1;
            if (w_hs)  w_done_reg  <= 1'b1;
            if (b_hs) begin
                rsp_valid_reg <= grant_onehot;
                rsp_data_reg  <= '0;
                rsp_err_reg   <= axil_bresp[1];
            end
            if (r_hs) begin
                rsp_valid_reg <= grant_onehot;
                rsp_data_reg  <= axil_rdata;
                rsp_err_reg   <= axil_rresp[1];
            end
        end
    end

    // Channel controls decode straight from state so reset clears them without waiting for a clock.
    assign axil_awvalid = (state_reg == WR_ADDR) && !aw_done_reg;
    assign axil_wvalid  = (state_reg == WR_ADDR) && !w_done_reg;
    assign axil_bready  = (state_reg == WR_RESP);
    assign axil_arvalid = (state_reg == RD_ADDR);
    assign axil_rready  = (state_reg == RD_DATA);
    assign axil_awaddr  = addr_reg;
    assign axil_araddr  = addr_reg;
    assign axil_wdata   = wdata_reg;
    assign axil_wstrb   = '1;
    assign axil_awprot  = 3'b000;
    assign axil_arprot  = 3'b000;

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign busy      = (state_reg != IDLE);
    assign grant_id  = grant_id_reg;

    assign unused_resp_bits = ^{axil_bresp[0], axil_rresp[0]};

endmodule

// File: tb/tb_regpool_access_arbiter.sv
// Scoreboard bench for regpool_access_arbiter: per-requester command queues feed a driver,
// expected responses are queued per requester and popped by an independent response monitor.
module tb_regpool_access_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam logic [31:0] TS_ADDR  = 32'h0000_0000;
    localparam logic [31:0] CFG_ADDR = 32'h0000_0010;
    localparam logic [31:0] BAD_ADDR = 32'h0000_0FFC;
    localparam logic [31:0] TS_VAL   = 32'h0000_0ABC;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic [NREQ-1:0]       req_valid, req_we, req_ready, rsp_valid;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*DW-1:0]    req_wdata;
    logic [AW-1:0]         req_addr_a  [NREQ];
    logic [DW-1:0]         req_wdata_a [NREQ];
    logic [DW-1:0]         rsp_data;
    logic                  rsp_err, busy;
    logic [1:0]            grant_id;
    logic [AW-1:0]         awaddr, araddr;
    logic [2:0]            awprot, arprot;
    logic                  awvalid, awready, wvalid, wready, bvalid, bready;
    logic                  arvalid, arready, rvalid, rready;
    logic [DW-1:0]         wdata, rdata;
    logic [DW/8-1:0]       wstrb;
    logic [1:0]            bresp, rresp;

    always #5 aclk = ~aclk;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
        assign req_addr[gi*AW +: AW]  = req_addr_a[gi];
        assign req_wdata[gi*DW +: DW] = req_wdata_a[gi];
    end

    regpool_access_arbiter #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .grant_id(grant_id),
        .axil_awaddr(awaddr), .axil_awprot(awprot), .axil_awvalid(awvalid), .axil_awready(awready),
        .axil_wdata(wdata), .axil_wstrb(wstrb), .axil_wvalid(wvalid), .axil_wready(wready),
        .axil_bresp(bresp), .axil_bvalid(bvalid), .axil_bready(bready),
        .axil_araddr(araddr), .axil_arprot(arprot), .axil_arvalid(arvalid), .axil_arready(arready),
        .axil_rdata(rdata), .axil_rresp(rresp), .axil_rvalid(rvalid), .axil_rready(rready)
    );

    // ---------------- AXI4-Lite slave model ----------------
    int          aw_delay = 0;
    int          r_delay  = 0;
    int          aw_cnt;
    int          r_cnt;
    int          b_count;
    logic        got_aw, got_w, r_pend;
    logic [31:0] aw_addr_s, w_data_s, r_addr_s;
    logic [31:0] core_cfg = 32'h0;
    logic [31:0] wr_addr_eff, wr_data_eff;

    assign awready     = (aw_cnt >= aw_delay);
    assign wready      = 1'b1;
    assign arready     = 1'b1;
    assign wr_addr_eff = got_aw ? aw_addr_s : awaddr;
    assign wr_data_eff = got_w  ? w_data_s  : wdata;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == TS_ADDR)  return TS_VAL;
        if (a == CFG_ADDR) return core_cfg;
        return 32'h0;
    endfunction

    function automatic logic [1:0] map_resp(input logic [31:0] a);
        return ((a == TS_ADDR) || (a == CFG_ADDR)) ? 2'b00 : 2'b10;
    endfunction

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0; r_pend <= 1'b0; r_cnt <= 0;
            b_count <= b_count;
        end else begin
            if (awvalid && awready)  aw_cnt <= 0;
            else if (awvalid)        aw_cnt <= aw_cnt + 1;
            if (awvalid && awready) begin got_aw <= 1'b1; aw_addr_s <= awaddr; end
            if (wvalid && wready)   begin got_w  <= 1'b1; w_data_s  <= wdata;  end
            if (bvalid && bready)   begin bvalid <= 1'b0; b_count <= b_count + 1; end
            if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready)) && !bvalid) begin
                if (wr_addr_eff == CFG_ADDR) core_cfg <= wr_data_eff;
                bresp  <= map_resp(wr_addr_eff);
                bvalid <= 1'b1;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                if (r_delay == 0) begin
                    rvalid <= 1'b1; rdata <= rd_val(araddr); rresp <= map_resp(araddr);
                end else begin
                    r_pend <= 1'b1; r_cnt <= r_delay - 1; r_addr_s <= araddr;
                end
            end
            if (r_pend) begin
                if (r_cnt == 0) begin
                    r_pend <= 1'b0; rvalid <= 1'b1;
                    rdata <= rd_val(r_addr_s); rresp <= map_resp(r_addr_s);
                end else begin
                    r_cnt <= r_cnt - 1;
                end
            end
        end
    end

    initial b_count = 0;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } cmd_t;
    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    cmd_t  cmd_q [NREQ][$];
    rsp_t  exp_q [NREQ][$];
    int    grant_log[$];
    int    total = 0;
    int    bad   = 0;
    logic [NREQ-1:0] acc = '0;
    cmd_t  drv_c;
    rsp_t  mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        cmd_q[id].push_back('{we, addr, wd, ed, ee});
    endtask

    task automatic step();
        @(negedge aclk);
        #2;
    endtask

    // Driver: presents each requester's next command, holds it until accepted.
    initial begin
        req_valid = '0;
        req_we    = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr_a[i]  = '0;
            req_wdata_a[i] = '0;
        end
        forever begin
            @(negedge aclk);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                    acc[i]       = 1'b0;
                end
                if (!req_valid[i] && !areset && cmd_q[i].size() != 0) begin
                    drv_c          = cmd_q[i].pop_front();
                    req_valid[i]   = 1'b1;
                    req_we[i]      = drv_c.we;
                    req_addr_a[i]  = drv_c.addr;
                    req_wdata_a[i] = drv_c.wdata;
                    exp_q[i].push_back('{drv_c.exp_data, drv_c.exp_err});
                end
            end
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc[i] = 1'b1;
                    grant_log.push_back(i);
                end
            end
        end
    end

    // Monitor: every response pulse must match the oldest outstanding expectation of its owner.
    initial begin
        forever begin
            step();
            if (!areset && rsp_valid != '0) begin
                chk("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
                for (int i = 0; i < NREQ; i++) begin
                    if (rsp_valid[i]) begin
                        if (exp_q[i].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL rsp_unexpected: req=%0d pulsed with data=%h, required no response", i, rsp_data);
                        end else begin
                            mon_e = exp_q[i].pop_front();
                            $display("rsp req=%0d data=%h err=%b", i, rsp_data, rsp_err);
                            chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
                            chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                        end
                    end
                end
            end
        end
    end

    task automatic wait_grant(input int id, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            step();
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: req=%0d never saw req_ready, required a grant", id);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += cmd_q[i].size() + exp_q[i].size();
        return s;
    endfunction

    task automatic wait_drain();
        bit done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            step();
            if (pending() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d items outstanding, required 0", pending());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    int exp_g[4] = '{0, 1, 0, 1};
    int b0;
    bit ok;

    initial begin
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_axi_valid", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_grant_id", 64'(grant_id), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        step();
        chk("idle_busy", 64'(busy), 64'd0);

        // Zero-wait read by requester 0: grant T0, AR T1, R T2, response T3
        push(0, 1'b0, TS_ADDR, 32'h0, TS_VAL, 1'b0);
        wait_grant(0, ok);
        if (ok) begin
            step();
            chk("t1_arvalid", 64'(arvalid), 64'd1);
            chk("t1_araddr", 64'(araddr), 64'(TS_ADDR));
            chk("t1_grant_id", 64'(grant_id), 64'd0);
            step();
            chk("t2_rready", 64'(rready), 64'd1);
            chk("t2_rsp_valid", 64'(rsp_valid), 64'd0);
            step();
            chk("t3_rsp_valid", 64'(rsp_valid), 64'b001);
            chk("t3_busy", 64'(busy), 64'd0);
        end
        wait_drain();

        // Error responses on unmapped address, write then read
        push(1, 1'b1, BAD_ADDR, 32'h1111_1111, 32'h0, 1'b1);
        push(2, 1'b0, BAD_ADDR, 32'h0, 32'h0, 1'b1);
        wait_drain();
        chk("err_idle_busy", 64'(busy), 64'd0);

        // AWREADY delayed by 3 cycles, WREADY immediate
        aw_delay = 3;
        b0 = b_count;
        push(0, 1'b1, CFG_ADDR, 32'h0000_0003, 32'h0, 1'b0);
        wait_grant(0, ok);
        if (ok) begin
            step();
            chk("aw_t1_awvalid", 64'(awvalid), 64'd1);
            chk("aw_t1_wvalid", 64'(wvalid), 64'd1);
            chk("aw_t1_wstrb", 64'(wstrb), 64'hF);
            step();
            chk("aw_t2_wvalid", 64'(wvalid), 64'd0);
            chk("aw_t2_awvalid", 64'(awvalid), 64'd1);
            step();
            step();
            chk("aw_t4_awvalid", 64'(awvalid), 64'd1);
            step();
            chk("aw_t5_awvalid", 64'(awvalid), 64'd0);
            chk("aw_t5_bready", 64'(bready), 64'd1);
        end
        wait_drain();
        chk("aw_b_count", 64'(b_count - b0), 64'd1);
        aw_delay = 0;

        // Requester 2 alone, back-to-back: regrant in every response cycle
        push(2, 1'b0, TS_ADDR, 32'h0, TS_VAL, 1'b0);
        push(2, 1'b1, CFG_ADDR, 32'h0000_0077, 32'h0, 1'b0);
        push(2, 1'b0, CFG_ADDR, 32'h0, 32'h0000_0077, 1'b0);
        wait_grant(2, ok);
        if (ok) begin
            for (int k = 0; k < 3; k++) begin
                step();
                chk("b2b_t1_busy", 64'(busy), 64'd1);
                step();
                step();
                chk("b2b_rsp_valid", 64'(rsp_valid), 64'b100);
                chk("b2b_busy_gap", 64'(busy), 64'd0);
                chk("b2b_regrant", 64'(req_ready), (k < 2) ? 64'b100 : 64'b000);
            end
        end
        wait_drain();
        chk("b2b_grant_id", 64'(grant_id), 64'd2);

        // Reset while waiting in RD_DATA: transaction abandoned, no response
        r_delay = 20;
        push(0, 1'b0, CFG_ADDR, 32'h0, 32'h0000_0077, 1'b0);
        wait_grant(0, ok);
        if (ok) begin
            step();
            step();
            step();
            chk("rst_pre_rready", 64'(rready), 64'd1);
            areset = 1'b1;
            #1;
            chk("rst_axi_valid", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_grant_id", 64'(grant_id), 64'd0);
            exp_q[0].delete();
            repeat (2) @(negedge aclk);
            areset  = 1'b0;
            r_delay = 0;
        end else begin
            r_delay = 0;
        end
        repeat (5) step();

        // Both requesters continuously active: grants alternate starting at 0
        grant_log.delete();
        push(0, 1'b1, CFG_ADDR, 32'hDEAD_BEEF, 32'h0, 1'b0);
        push(0, 1'b1, CFG_ADDR, 32'h0000_5A5A, 32'h0, 1'b0);
        push(1, 1'b0, CFG_ADDR, 32'h0, 32'hDEAD_BEEF, 1'b0);
        push(1, 1'b0, CFG_ADDR, 32'h0, 32'h0000_5A5A, 1'b0);
        wait_drain();
        chk("rr_grant_count", 64'(grant_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < grant_log.size()) chk("rr_grant_order", 64'(grant_log[k]), 64'(exp_g[k]));
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
